// File: rtl/memory_block_fetcher.sv
// memory_block_fetcher: read-only word memory serving 4-word cache line fills, critical word
// first with wrap-around. Define MEM_FETCH_STATS_EN for fill/busy counters and a per-fill log.
module memory_block_fetcher #(
  parameter int    ADDR_W    = 15,
  parameter int    DATA_W    = 32,
  parameter int    LATENCY   = 4,
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              fill_req,
  input  logic [ADDR_W-1:0] fill_addr,
  output logic              busy,
  output logic              fill_valid,
  output logic [DATA_W-1:0] fill_data,
  output logic [1:0]        fill_word,
  output logic              fill_last
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_BEAT
  } state_e;

  localparam int         BASE_W = ADDR_W - 2;
  localparam logic [3:0] LAT    = 4'(LATENCY);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  state_e            state_q, state_d;
  logic [BASE_W-1:0] base_q, base_d;
  logic [1:0]        start_q, start_d;
  logic [3:0]        lat_cnt_q, lat_cnt_d;
  logic [1:0]        beat_q, beat_d;

  logic              busy_q, busy_d;
  logic              fill_valid_q, fill_valid_d;
  logic              fill_last_q, fill_last_d;
  logic [1:0]        fill_word_q, fill_word_d;
  logic [DATA_W-1:0] fill_data_q;
  logic [ADDR_W-1:0] rd_addr_d;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave it unassigned (no latches).
    state_d   = state_q;
    base_d    = base_q;
    start_d   = start_q;
    lat_cnt_d = lat_cnt_q;
    beat_d    = beat_q;

    unique case (state_q)
      ST_IDLE: begin
        if (fill_req) begin
          base_d    = fill_addr[ADDR_W-1:2];
          start_d   = fill_addr[1:0];
          lat_cnt_d = LAT;
          beat_d    = 2'd0;
          state_d   = (LAT != 4'd0) ? ST_WAIT : ST_BEAT;
        end
      end
      ST_WAIT: begin
        lat_cnt_d = lat_cnt_q - 4'd1;
        if (lat_cnt_q == 4'd1) state_d = ST_BEAT;
      end
      ST_BEAT: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    busy_d       = (state_d != ST_IDLE);
    fill_valid_d = (state_d == ST_BEAT);
    fill_word_d  = fill_valid_d ? (start_d + beat_d) : 2'd0;
    fill_last_d  = fill_valid_d && (beat_d == 2'd3);
    rd_addr_d    = {base_d, fill_word_d};
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= ST_IDLE;
      base_q       <= '0;
      start_q      <= '0;
      lat_cnt_q    <= '0;
      beat_q       <= '0;
      busy_q       <= 1'b0;
      fill_valid_q <= 1'b0;
      fill_last_q  <= 1'b0;
      fill_word_q  <= '0;
      fill_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      start_q      <= start_d;
      lat_cnt_q    <= lat_cnt_d;
      beat_q       <= beat_d;
      busy_q       <= busy_d;
      fill_valid_q <= fill_valid_d;
      fill_last_q  <= fill_last_d;
      fill_word_q  <= fill_word_d;
      // NOTE: the memory array itself is never reset; only its registered read port is.
      fill_data_q  <= fill_valid_d ? mem[rd_addr_d] : '0;
    end
  end

  assign busy       = busy_q;
  assign fill_valid = fill_valid_q;
  assign fill_data  = fill_data_q;
  assign fill_word  = fill_word_q;
  assign fill_last  = fill_last_q;

`ifdef MEM_FETCH_STATS_EN
  integer fills_served;
  integer busy_cycles;

  // An aborted fill never shows fill_last, so it is never counted as served.
  always_ff @(posedge clk) begin
    if (clear) begin
      fills_served <= 0;
      busy_cycles  <= 0;
    end else begin
      if (busy_q) busy_cycles <= busy_cycles + 1;
      if (fill_last_q) begin
        fills_served <= fills_served + 1;
        $display("@%0t: MEM: fills: %0d busy: %0d", $time, fills_served + 1, busy_cycles + 1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_memory_block_fetcher.sv
// Bench for memory_block_fetcher: two instances (LATENCY 4 and 0), an edge-indexed transaction
// model checked every cycle, plus directed scenarios with literal expectations.
module tb_memory_block_fetcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clear_a = 1'b0, req_a = 1'b0, clear_b = 1'b0, req_b = 1'b0;
  logic [14:0] addr_a = '0, addr_b = '0;
  logic        busy_a, valid_a, last_a, busy_b, valid_b, last_b;
  logic [31:0] data_a, data_b;
  logic [1:0]  word_a, word_b;

  memory_block_fetcher #(.ADDR_W(15), .DATA_W(32), .LATENCY(4), .INIT_FILE("")) dut_a (
    .clk(clk), .clear(clear_a), .fill_req(req_a), .fill_addr(addr_a), .busy(busy_a),
    .fill_valid(valid_a), .fill_data(data_a), .fill_word(word_a), .fill_last(last_a)
  );

  memory_block_fetcher #(.ADDR_W(15), .DATA_W(32), .LATENCY(0), .INIT_FILE("")) dut_b (
    .clk(clk), .clear(clear_b), .fill_req(req_b), .fill_addr(addr_b), .busy(busy_b),
    .fill_valid(valid_b), .fill_data(data_b), .fill_word(word_b), .fill_last(last_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model: one transaction per instance, indexed by clock edge ----------------
  logic [31:0] model_mem [0:32767];
  int          edge_cnt = 0;
  int          acc_edge [2] = '{-1000, -1000};
  int          busy_end [2] = '{-1000, -1000};
  logic [14:0] acc_addr [2] = '{15'd0, 15'd0};
  bit          armed    [2] = '{1'b0, 1'b0};

  function automatic int lat_of(int id);
    return (id == 0) ? 4 : 0;
  endfunction

  // A request is seen only if the period before this edge was idle; clear wins and aborts.
  function automatic void model_step(int id, logic clr, logic req, logic [14:0] addr);
    if (clr) begin
      busy_end[id] = edge_cnt - 1;
      acc_edge[id] = -1000;
      armed[id]    = 1'b1;
    end else if (req && (edge_cnt - 1 > busy_end[id])) begin
      acc_edge[id] = edge_cnt;
      acc_addr[id] = addr;
      busy_end[id] = edge_cnt + 3 + lat_of(id);
    end
  endfunction

  always @(posedge clk) begin
    edge_cnt++;
    model_step(0, clear_a, req_a, addr_a);
    model_step(1, clear_b, req_b, addr_b);
  end

  task automatic compare(int id, logic busy, logic valid, logic [31:0] data, logic [1:0] word,
                         logic last);
    int          k;
    logic        eb, ev, el;
    logic [1:0]  ew;
    logic [31:0] ed;
    string       tag;
    if (!armed[id]) return;
    tag = (id == 0) ? "a" : "b";
    eb  = (acc_edge[id] <= edge_cnt) && (edge_cnt <= busy_end[id]);
    k   = edge_cnt - acc_edge[id] - lat_of(id);
    ev  = eb && (k >= 0);
    ew  = ev ? 2'((int'(acc_addr[id][1:0]) + k) % 4) : 2'd0;
    ed  = ev ? model_mem[{acc_addr[id][14:2], ew}] : 32'd0;
    el  = ev && (k == 3);
    check({tag, "_busy"}, {31'd0, busy}, {31'd0, eb});
    check({tag, "_valid"}, {31'd0, valid}, {31'd0, ev});
    check({tag, "_word"}, {30'd0, word}, {30'd0, ew});
    check({tag, "_data"}, data, ed);
    check({tag, "_last"}, {31'd0, last}, {31'd0, el});
  endtask

  // Beat logs of what the DUTs actually produced, for the literal checks below.
  logic [31:0] log_data_a [$], log_data_b [$];
  logic [1:0]  log_word_a [$], log_word_b [$];
  logic        log_last_a [$], log_last_b [$];
  int          log_edge_a [$], log_edge_b [$];

  always @(negedge clk) begin
    compare(0, busy_a, valid_a, data_a, word_a, last_a);
    compare(1, busy_b, valid_b, data_b, word_b, last_b);
    if (valid_a) begin
      log_data_a.push_back(data_a); log_word_a.push_back(word_a);
      log_last_a.push_back(last_a); log_edge_a.push_back(edge_cnt);
    end
    if (valid_b) begin
      log_data_b.push_back(data_b); log_word_b.push_back(word_b);
      log_last_b.push_back(last_b); log_edge_b.push_back(edge_cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clear_logs();
    log_data_a.delete(); log_word_a.delete(); log_last_a.delete(); log_edge_a.delete();
    log_data_b.delete(); log_word_b.delete(); log_last_b.delete(); log_edge_b.delete();
  endtask

  task automatic put(logic [14:0] a, logic [31:0] v);
    model_mem[a]  = v;
    dut_a.mem[a]  = v;
    dut_b.mem[a]  = v;
  endtask

  // Returns the edge at which the pulse is sampled.
  task automatic pulse_a(logic [14:0] a, output int req_edge);
    req_a    = 1'b1;
    addr_a   = a;
    req_edge = edge_cnt + 1;
    tick(1);
    req_a    = 1'b0;
  endtask

  // Checks a 4-beat block on instance a: words start,start+1,.. and data base_v+word.
  task automatic check_block_a(string name, logic [1:0] start, logic [31:0] base_v);
    logic [1:0] w;
    check({name, "_beats"}, log_data_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      w = start + 2'(i);
      check($sformatf("%s_word%0d", name, i), {30'd0, log_word_a[i]}, {30'd0, w});
      check($sformatf("%s_data%0d", name, i), log_data_a[i], base_v + {30'd0, w});
      check($sformatf("%s_last%0d", name, i), {31'd0, log_last_a[i]}, (i == 3) ? 1 : 0);
    end
  endtask

  initial begin
    int          req_edge;
    logic [8:0]  bh, vh;
    int          exp_off [8];

    for (int i = 0; i < 4; i++) begin
      put(15'h0100 + 15'(i), 32'hA0 + 32'(i));
      put(15'h0104 + 15'(i), 32'hB0 + 32'(i));
      put(15'h7FFC + 15'(i), 32'hC0 + 32'(i));
    end

    // Reset held 2 cycles with fill_req high: nothing accepted.
    clear_a = 1'b1; clear_b = 1'b1; req_a = 1'b1; req_b = 1'b1;
    addr_a = 15'h0100; addr_b = 15'h0100;
    tick(2);
    check("rst_busy_a", {31'd0, busy_a}, 0);
    check("rst_valid_a", {31'd0, valid_a}, 0);
    check("rst_data_a", data_a, 0);
    check("rst_word_a", {30'd0, word_a}, 0);
    check("rst_last_a", {31'd0, last_a}, 0);
    check("rst_busy_b", {31'd0, busy_b}, 0);
    clear_a = 1'b0; clear_b = 1'b0; req_a = 1'b0; req_b = 1'b0;
    tick(3);

    // Aligned fill, LATENCY 4: busy spans 8 cycles, beats in the last four.
    clear_logs();
    pulse_a(15'h0100, req_edge);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      bh[i] = busy_a;
      vh[i] = valid_a;
    end
    check("al_busy_hist", {23'd0, bh}, {23'd0, 9'b0_1111_1111});
    check("al_valid_hist", {23'd0, vh}, {23'd0, 9'b0_1111_0000});
    tick(2);
    check_block_a("al", 2'd0, 32'hA0);
    for (int i = 0; i < 4; i++)
      check($sformatf("al_offset%0d", i), log_edge_a[i] - req_edge, 4 + i);

    // Wrap-around from word 2.
    clear_logs();
    pulse_a(15'h0106, req_edge);
    tick(11);
    check_block_a("wr", 2'd2, 32'hB0);

    // Request during WAIT is dropped: exactly one burst.
    clear_logs();
    pulse_a(15'h0100, req_edge);
    tick(1);
    pulse_a(15'h7FFC, req_edge);
    tick(12);
    check_block_a("ig", 2'd0, 32'hA0);

    // Clear during beat 2 aborts the fill.
    clear_logs();
    pulse_a(15'h0104, req_edge);
    tick(6);
    clear_a = 1'b1;
    tick(1);
    clear_a = 1'b0;
    @(negedge clk);
    check("ab_valid", {31'd0, valid_a}, 0);
    check("ab_busy", {31'd0, busy_a}, 0);
    tick(3);
    check("ab_beats", log_data_a.size(), 3);
    for (int i = 0; i < 3; i++)
      check($sformatf("ab_data%0d", i), log_data_a[i], 32'hB0 + 32'(i));
    clear_logs();
    pulse_a(15'h0100, req_edge);
    tick(11);
    check_block_a("rc", 2'd0, 32'hA0);

    // LATENCY 0, request held: first beat right after acceptance, re-accepted after busy falls.
    clear_logs();
    req_b    = 1'b1;
    addr_b   = 15'h7FFF;
    req_edge = edge_cnt + 1;
    tick(10);
    req_b = 1'b0;
    tick(6);
    exp_off = '{0, 1, 2, 3, 5, 6, 7, 8};
    check("bb_beats", log_data_b.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bb_offset%0d", i), log_edge_b[i] - req_edge, exp_off[i]);
      check($sformatf("bb_word%0d", i), {30'd0, log_word_b[i]}, (3 + i) % 4);
      check($sformatf("bb_data%0d", i), log_data_b[i], 32'hC0 + 32'((3 + i) % 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
